md_unit: RTL and testbench

- Multiply/divide unit for the E stage of the pipelined MIPS core, downstream of the E-stage forwarding muxes.
- Consumes forwarded rs/rt operands and a decoded md operation.
- Holds the HI/LO architectural registers and models multi-cycle latency with a busy counter.
- Controller stalls D-stage md instructions on busy|start.

---
 rtl/md_unit_pkg.sv | 42 ++++
 rtl/md_calc.sv | 70 +++++++
 rtl/md_unit.sv | 112 +++++++++++
 tb/tb_md_unit.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/md_unit_pkg.sv
// Shared definitions for the multiply/divide unit: operand width, md_op
// encodings, operation classes and controller states.
// Optional feature macro: MD_MADD_EN (widens md_op to 4 bits and adds the
// multiply-accumulate codes MADD/MSUB/MADDU/MSUBU).
package md_unit_pkg;

  localparam int DATA_W = 32;

`ifdef MD_MADD_EN
  localparam int MD_OP_W = 4;
`else
  localparam int MD_OP_W = 3;
`endif

  localparam logic [MD_OP_W-1:0] MD_MULT  = MD_OP_W'(0);
  localparam logic [MD_OP_W-1:0] MD_MULTU = MD_OP_W'(1);
  localparam logic [MD_OP_W-1:0] MD_DIV   = MD_OP_W'(2);
  localparam logic [MD_OP_W-1:0] MD_DIVU  = MD_OP_W'(3);
  localparam logic [MD_OP_W-1:0] MD_MTHI  = MD_OP_W'(4);
  localparam logic [MD_OP_W-1:0] MD_MTLO  = MD_OP_W'(5);
  localparam logic [MD_OP_W-1:0] MD_MADD  = MD_OP_W'(6);
  localparam logic [MD_OP_W-1:0] MD_MSUB  = MD_OP_W'(7);
`ifdef MD_MADD_EN
  localparam logic [MD_OP_W-1:0] MD_MADDU = MD_OP_W'(8);
  localparam logic [MD_OP_W-1:0] MD_MSUBU = MD_OP_W'(9);
`endif

  // How the sequencer treats an operation: multi-cycle multiply, multi-cycle
  // divide, single-cycle HI/LO move, or nothing at all.
  typedef enum logic [1:0] {
    MD_CLS_NOP,
    MD_CLS_MUL,
    MD_CLS_DIV,
    MD_CLS_MOVE
  } md_cls_t;

  typedef enum logic {
    MD_IDLE,
    MD_RUN
  } md_state_t;

endpackage

// File: rtl/md_calc.sv
// Combinational result generator for the multiply/divide unit. Produces the
// full 64-bit {hi,lo} result for every md_op, the operation class and a
// divide-by-zero flag. Honors MD_MADD_EN for the multiply-accumulate codes.
module md_calc
  import md_unit_pkg::*;
(
  input  logic [MD_OP_W-1:0] md_op,
  input  logic [DATA_W-1:0]  rs_val,
  input  logic [DATA_W-1:0]  rt_val,
  input  logic [DATA_W-1:0]  hi,
  input  logic [DATA_W-1:0]  lo,
  output logic [DATA_W-1:0]  res_hi,
  output logic [DATA_W-1:0]  res_lo,
  output md_cls_t            cls,
  output logic               div_zero
);

  logic signed [2*DATA_W-1:0] prod_s;
  logic        [2*DATA_W-1:0] prod_u;
  logic signed [DATA_W:0]     dvd_s;
  logic signed [DATA_W:0]     dvs_s;
  logic        [DATA_W-1:0]   dvs_u;
  logic        [DATA_W-1:0]   quo_s;
  logic        [DATA_W-1:0]   rem_s;
  logic        [DATA_W-1:0]   quo_u;
  logic        [DATA_W-1:0]   rem_u;
`ifdef MD_MADD_EN
  logic        [2*DATA_W-1:0] acc;
  assign acc = {hi, lo};
`endif

  assign prod_s = $signed({{DATA_W{rs_val[DATA_W-1]}}, rs_val})
                * $signed({{DATA_W{rt_val[DATA_W-1]}}, rt_val});
  assign prod_u = {{DATA_W{1'b0}}, rs_val} * {{DATA_W{1'b0}}, rt_val};

  // A zero divisor is forced to 1 so the divider always sees a legal operand;
  // the divide-by-zero result is never committed. The signed divide runs one
  // bit wider so 0x80000000 / -1 yields 2^31, which truncates to 0x80000000.
  assign div_zero = (rt_val == '0);
  assign dvd_s    = $signed({rs_val[DATA_W-1], rs_val});
  assign dvs_s    = $signed({rt_val[DATA_W-1], rt_val[DATA_W-1:1], rt_val[0] | div_zero});
  assign dvs_u    = {rt_val[DATA_W-1:1], rt_val[0] | div_zero};
  assign quo_s    = DATA_W'(dvd_s / dvs_s);
  assign rem_s    = DATA_W'(dvd_s % dvs_s);
  assign quo_u    = rs_val / dvs_u;
  assign rem_u    = rs_val % dvs_u;

  // Select the result and class for the decoded operation; unknown codes keep hi/lo.
  always_comb begin
    res_hi = hi;
    res_lo = lo;
    cls    = MD_CLS_NOP;
    case (md_op)
      MD_MULT:  begin {res_hi, res_lo} = prod_s;         cls = MD_CLS_MUL;  end
      MD_MULTU: begin {res_hi, res_lo} = prod_u;         cls = MD_CLS_MUL;  end
      MD_DIV:   begin res_hi = rem_s; res_lo = quo_s;    cls = MD_CLS_DIV;  end
      MD_DIVU:  begin res_hi = rem_u; res_lo = quo_u;    cls = MD_CLS_DIV;  end
      MD_MTHI:  begin res_hi = rs_val;                   cls = MD_CLS_MOVE; end
      MD_MTLO:  begin res_lo = rs_val;                   cls = MD_CLS_MOVE; end
`ifdef MD_MADD_EN
      MD_MADD:  begin {res_hi, res_lo} = acc + prod_s;   cls = MD_CLS_MUL;  end
      MD_MSUB:  begin {res_hi, res_lo} = acc - prod_s;   cls = MD_CLS_MUL;  end
      MD_MADDU: begin {res_hi, res_lo} = acc + prod_u;   cls = MD_CLS_MUL;  end
      MD_MSUBU: begin {res_hi, res_lo} = acc - prod_u;   cls = MD_CLS_MUL;  end
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/md_unit.sv
// E-stage multiply/divide unit: holds the HI/LO registers and models the
// multi-cycle latency of MULT/DIV with a busy counter. The result is computed
// at issue, parked in a pending register and committed when busy falls.
// Optional feature macro: MD_MADD_EN (multiply-accumulate ops, see md_calc).
module md_unit
  import md_unit_pkg::*;
#(
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10
)
(
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [MD_OP_W-1:0] md_op,
  input  logic [DATA_W-1:0]  rs_val,
  input  logic [DATA_W-1:0]  rt_val,
  output logic               busy,
  output logic [DATA_W-1:0]  hi,
  output logic [DATA_W-1:0]  lo
);

  localparam logic [3:0] MULT_CNT = 4'(MULT_LAT);
  localparam logic [3:0] DIV_CNT  = 4'(DIV_LAT);

  md_state_t         state;
  logic [3:0]        cnt;
  logic              pend_we;
  logic [DATA_W-1:0] pend_hi_p1;
  logic [DATA_W-1:0] pend_lo_p1;
  logic [DATA_W-1:0] calc_hi;
  logic [DATA_W-1:0] calc_lo;
  md_cls_t           calc_cls;
  logic              calc_div_zero;
  logic              issue;

  md_calc u_calc (
    .md_op    (md_op),
    .rs_val   (rs_val),
    .rt_val   (rt_val),
    .hi       (hi),
    .lo       (lo),
    .res_hi   (calc_hi),
    .res_lo   (calc_lo),
    .cls      (calc_cls),
    .div_zero (calc_div_zero)
  );

  assign issue = (state == MD_IDLE) && start;

  // Sequencer: issue from IDLE, count down in RUN, commit pending on the last busy edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= MD_IDLE;
      busy    <= 1'b0;
      cnt     <= '0;
      pend_we <= 1'b0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      case (state)
        MD_IDLE: begin
          if (start) begin
            case (calc_cls)
              MD_CLS_MUL: begin
                state   <= MD_RUN;
                busy    <= 1'b1;
                cnt     <= MULT_CNT;
                pend_we <= 1'b1;
              end
              MD_CLS_DIV: begin
                state   <= MD_RUN;
                busy    <= 1'b1;
                cnt     <= DIV_CNT;
                pend_we <= ~calc_div_zero;
              end
              MD_CLS_MOVE: begin
                hi <= calc_hi;
                lo <= calc_lo;
              end
              default: ;
            endcase
          end
        end
        MD_RUN: begin
          if (cnt == 4'd1) begin
            state   <= MD_IDLE;
            busy    <= 1'b0;
            cnt     <= '0;
            pend_we <= 1'b0;
            if (pend_we) begin
              hi <= pend_hi_p1;
              lo <= pend_lo_p1;
            end
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Pending result capture at issue; only committed when pend_we says so.
  always_ff @(posedge clk) begin
    if (issue) begin
      pend_hi_p1 <= calc_hi;
      pend_lo_p1 <= calc_lo;
    end
  end

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: a behavioural HI/LO model compared every
// cycle, plus directed operations with hand-computed expected values.
module tb_md_unit;
  import md_unit_pkg::MD_OP_W;

  localparam int MULT_LAT = 5;
  localparam int DIV_LAT  = 10;

  logic               clk    = 1'b0;
  logic               reset  = 1'b1;
  logic               start  = 1'b0;
  logic [MD_OP_W-1:0] md_op  = '0;
  logic [31:0]        rs_val = '0;
  logic [31:0]        rt_val = '0;
  logic               busy;
  logic [31:0]        hi;
  logic [31:0]        lo;

  int checks = 0;
  int errors = 0;

  md_unit #(.MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .md_op  (md_op),
    .rs_val (rs_val),
    .rt_val (rt_val),
    .busy   (busy),
    .hi     (hi),
    .lo     (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Behavioural model: architectural HI/LO, remaining busy cycles, pending result.
  logic [31:0] m_hi = '0, m_lo = '0, m_phi = '0, m_plo = '0;
  int          m_left = 0;
  bit          m_we = 1'b0;
  longint      ma, mb, mr;
  logic [63:0] macc;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_hi = '0; m_lo = '0; m_left = 0; m_we = 1'b0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0 && m_we) begin
        m_hi = m_phi;
        m_lo = m_plo;
      end
    end else if (start) begin
      case (int'(md_op))
        0: begin
          mr = longint'($signed(rs_val)) * longint'($signed(rt_val));
          {m_phi, m_plo} = mr; m_we = 1'b1; m_left = MULT_LAT;
        end
        1: begin
          mr = longint'({32'b0, rs_val}) * longint'({32'b0, rt_val});
          {m_phi, m_plo} = mr; m_we = 1'b1; m_left = MULT_LAT;
        end
        2, 3: begin
          m_left = DIV_LAT;
          m_we   = (rt_val != 0);
          if (int'(md_op) == 2) begin
            ma = longint'($signed(rs_val)); mb = longint'($signed(rt_val));
          end else begin
            ma = longint'({32'b0, rs_val}); mb = longint'({32'b0, rt_val});
          end
          if (rt_val != 0) begin
            mr = ma / mb; m_plo = mr[31:0];
            mr = ma % mb; m_phi = mr[31:0];
          end
        end
        4: m_hi = rs_val;
        5: m_lo = rs_val;
`ifdef MD_MADD_EN
        6, 7, 8, 9: begin
          macc = {m_hi, m_lo};
          if (int'(md_op) <= 7) mr = longint'($signed(rs_val)) * longint'($signed(rt_val));
          else                  mr = longint'({32'b0, rs_val}) * longint'({32'b0, rt_val});
          if (int'(md_op) == 6 || int'(md_op) == 8) macc = macc + 64'(mr);
          else                                      macc = macc - 64'(mr);
          {m_phi, m_plo} = macc; m_we = 1'b1; m_left = MULT_LAT;
        end
`endif
        default: ;
      endcase
    end
  end

  // Every-cycle comparison of DUT outputs against the model.
  always @(negedge clk) begin
    check("busy", 64'(busy), 64'(m_left > 0));
    check("hi", 64'(hi), 64'(m_hi));
    check("lo", 64'(lo), 64'(m_lo));
  end

  task automatic do_op(input int op, input logic [31:0] a, input logic [31:0] b,
                       input int exp_busy, input string nm);
    int n;
    @(negedge clk);
    start = 1'b1; md_op = MD_OP_W'(op); rs_val = a; rt_val = b;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      n++;
      @(negedge clk);
    end
    check({nm, " busy cycles"}, 64'(n), 64'(exp_busy));
  endtask

  task automatic expect_hilo(input string nm, input logic [31:0] eh, input logic [31:0] el);
    check({nm, " hi"}, 64'(hi), 64'(eh));
    check({nm, " lo"}, 64'(lo), 64'(el));
  endtask

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not finish, got no end, expected end");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    repeat (2) @(negedge clk);
    check("reset busy", 64'(busy), 64'(0));
    expect_hilo("reset", 32'h0, 32'h0);
    reset = 1'b0;

    do_op(0, 32'hFFFF_FFFE, 32'd3, MULT_LAT, "mult");
    expect_hilo("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    do_op(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MULT_LAT, "multu");
    expect_hilo("multu", 32'hFFFF_FFFE, 32'h0000_0001);
    do_op(2, 32'hFFFF_FFF9, 32'd2, DIV_LAT, "div");
    expect_hilo("div", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    do_op(2, 32'h8000_0000, 32'hFFFF_FFFF, DIV_LAT, "div ovf");
    expect_hilo("div ovf", 32'h0, 32'h8000_0000);
    do_op(3, 32'd100, 32'd7, DIV_LAT, "divu");
    expect_hilo("divu", 32'd2, 32'd14);
    do_op(4, 32'h11, 32'h0, 0, "mthi");
    do_op(5, 32'h22, 32'h0, 0, "mtlo");
    expect_hilo("mthi/mtlo", 32'h11, 32'h22);
    do_op(3, 32'd7, 32'd0, DIV_LAT, "divu by zero");
    expect_hilo("divu by zero", 32'h11, 32'h22);
`ifdef MD_MADD_EN
    do_op(10, 32'h5, 32'h6, 0, "undef op");
`else
    do_op(6, 32'h5, 32'h6, 0, "undef op");
`endif
    expect_hilo("undef op", 32'h11, 32'h22);

    // MULT 2*3 with MTHI and DIV attempts during busy cycles 2 and 3.
    @(negedge clk);
    start = 1'b1; md_op = MD_OP_W'(0); rs_val = 32'd2; rt_val = 32'd3;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      n++;
      if (n == 2) begin start = 1'b1; md_op = MD_OP_W'(4); rs_val = 32'hDEAD; end
      if (n == 3) begin md_op = MD_OP_W'(2); rs_val = 32'd100; rt_val = 32'd7; end
      if (n == 4) start = 1'b0;
      @(negedge clk);
    end
    start = 1'b0;
    check("start while busy busy cycles", 64'(n), 64'(MULT_LAT));
    expect_hilo("start while busy", 32'h0, 32'h6);

`ifdef MD_MADD_EN
    do_op(4, 32'h0, 32'h0, 0, "mthi 0");
    do_op(5, 32'd10, 32'h0, 0, "mtlo 10");
    do_op(6, 32'd2, 32'd3, MULT_LAT, "madd");
    expect_hilo("madd", 32'h0, 32'd16);
    do_op(7, 32'd1, 32'd20, MULT_LAT, "msub");
    expect_hilo("msub", 32'hFFFF_FFFF, 32'hFFFF_FFFC);
    do_op(8, 32'hFFFF_FFFF, 32'd2, MULT_LAT, "maddu");
    expect_hilo("maddu", 32'h0000_0001, 32'hFFFF_FFFA);
    do_op(9, 32'd1, 32'd2, MULT_LAT, "msubu");
    expect_hilo("msubu", 32'h0000_0001, 32'hFFFF_FFF8);
`endif

    // Asynchronous reset in busy cycle 3 of a DIV.
    do_op(4, 32'h77, 32'h0, 0, "mthi 77");
    @(negedge clk);
    start = 1'b1; md_op = MD_OP_W'(2); rs_val = 32'd100; rt_val = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("async reset busy", 64'(busy), 64'(0));
    expect_hilo("async reset", 32'h0, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    repeat (12) @(negedge clk);
    check("after reset busy", 64'(busy), 64'(0));
    expect_hilo("after reset", 32'h0, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
